// File: rtl/taxi_fare_ctrl_pkg.sv
// Shared encodings, widths and default rates for the taxi meter fare engine.
// Used by the interface, the prescaler and the taxi_fare_ctrl top.
package taxi_pkg;

    localparam int DIST_W = 16;
    localparam int FARE_W = 14;

    typedef logic [1:0] drive_stat_t;

    localparam drive_stat_t ST_IDLE  = 2'b00;
    localparam drive_stat_t ST_WAIT  = 2'b01;
    localparam drive_stat_t ST_DRIVE = 2'b10;

    localparam int DEF_CLK_TICKS_PER_SEC = 50_000_000;
    localparam int DEF_PULSES_PER_UNIT   = 10;
    localparam int DEF_BASE_FARE         = 130;
    localparam int DEF_BASE_DIST         = 30;
    localparam int DEF_DIST_FARE         = 2;
    localparam int DEF_WAIT_UNIT_SEC     = 60;
    localparam int DEF_WAIT_FARE         = 5;
    localparam int DEF_FARE_MAX          = 9999;

    localparam logic [DIST_W-1:0] DIST_ONE = DIST_W'(1);

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
        return (v == '1) ? v : v + DIST_ONE;
    endfunction

endpackage

// File: rtl/taxi_fare_ctrl_if.sv
// Strobe inputs and display outputs of the fare engine.
// TAXI_NIGHT_RATE_EN adds the night_mode input.
interface taxi_fare_ctrl_if;
    import taxi_pkg::*;

`ifdef TAXI_NIGHT_RATE_EN
    logic              night_mode;
`endif
    logic              stat_change;
    logic              trip_end;
    logic              pulse_tick;
    logic [1:0]        drive_stat;
    logic              trip_active;
    logic [DIST_W-1:0] distance;
    logic [DIST_W-1:0] wait_sec;
    logic [FARE_W-1:0] fare;

    modport master (
`ifdef TAXI_NIGHT_RATE_EN
        output night_mode,
`endif
        output stat_change,
        output trip_end,
        output pulse_tick,
        input  drive_stat,
        input  trip_active,
        input  distance,
        input  wait_sec,
        input  fare
    );

    modport slave (
`ifdef TAXI_NIGHT_RATE_EN
        input  night_mode,
`endif
        input  stat_change,
        input  trip_end,
        input  pulse_tick,
        output drive_stat,
        output trip_active,
        output distance,
        output wait_sec,
        output fare
    );

endinterface

// File: rtl/taxi_fare_ctrl_tick_prescaler.sv
// Modulo-N event counter; o_wrap is combinational so the consumer updates on
// the same edge that samples the completing event.
module tick_prescaler #(
    parameter int N = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_wrap
);

    localparam int            W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0]  LAST = W'(N - 1);
    localparam logic [W-1:0]  ONE  = W'(1);

    logic [W-1:0] r_cnt;

    assign o_wrap = i_en && !i_clr && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_wrap ? '0 : r_cnt + ONE;
        end
    end

endmodule

// File: rtl/taxi_fare_ctrl.sv
// Taxi meter trip sequencer and fare accumulator (IDLE/WAIT/DRIVE).
// Optional TAXI_NIGHT_RATE_EN doubles distance/wait charges for night trips.
//
//   state    | meaning
//   ST_IDLE  | no trip; last trip's distance/wait/fare held on display
//   ST_WAIT  | trip paused; clocks counted as waiting seconds
//   ST_DRIVE | trip moving; wheel pulses counted as distance
module taxi_fare_ctrl
    import taxi_pkg::*;
#(
    parameter int CLK_TICKS_PER_SEC = DEF_CLK_TICKS_PER_SEC,
    parameter int PULSES_PER_UNIT   = DEF_PULSES_PER_UNIT,
    parameter int BASE_FARE         = DEF_BASE_FARE,
    parameter int BASE_DIST         = DEF_BASE_DIST,
    parameter int DIST_FARE         = DEF_DIST_FARE,
    parameter int WAIT_UNIT_SEC     = DEF_WAIT_UNIT_SEC,
    parameter int WAIT_FARE         = DEF_WAIT_FARE,
    parameter int FARE_MAX          = DEF_FARE_MAX
) (
    input logic            sys_clk,
    input logic            sys_rst,
    taxi_fare_ctrl_if.slave bus
);

    localparam int                SUM_W     = FARE_W + 4;
    localparam logic [SUM_W-1:0]  SUM_MAX   = SUM_W'(FARE_MAX);
    localparam logic [FARE_W-1:0] FARE_CAP  = FARE_W'(FARE_MAX);
    localparam logic [FARE_W-1:0] FARE_BASE = (BASE_FARE > FARE_MAX) ? FARE_CAP
                                                                     : FARE_W'(BASE_FARE);

    drive_stat_t       r_state;
    drive_stat_t       w_state_nxt;
    logic              r_trip_active;
    logic [DIST_W-1:0] r_distance;
    logic [DIST_W-1:0] r_wait_sec;
    logic [FARE_W-1:0] r_fare;

    logic w_trip_start;
    logic w_in_drive;
    logic w_in_wait;
    logic w_unit_wrap;
    logic w_sec_wrap;
    logic w_wunit_wrap;

    logic [DIST_W-1:0] w_dist_inc;
    logic [SUM_W-1:0]  w_dist_fare;
    logic [SUM_W-1:0]  w_wait_fare;
    logic [SUM_W-1:0]  w_dist_add;
    logic [SUM_W-1:0]  w_wait_add;
    logic [SUM_W-1:0]  w_fare_sum;
    logic [FARE_W-1:0] w_fare_sat;

    assign w_in_drive   = (r_state == ST_DRIVE);
    assign w_in_wait    = (r_state == ST_WAIT);
    assign w_trip_start = (r_state == ST_IDLE) && bus.stat_change;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.stat_change) w_state_nxt = ST_DRIVE;
            end
            ST_WAIT: begin
                if (bus.trip_end)         w_state_nxt = ST_IDLE;
                else if (bus.stat_change) w_state_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (bus.trip_end)         w_state_nxt = ST_IDLE;
                else if (bus.stat_change) w_state_nxt = ST_WAIT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    tick_prescaler #(.N(PULSES_PER_UNIT)) u_pulse_unit (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .i_en   (w_in_drive && bus.pulse_tick),
        .i_clr  (w_trip_start),
        .o_wrap (w_unit_wrap)
    );

    tick_prescaler #(.N(CLK_TICKS_PER_SEC)) u_clk_sec (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .i_en   (w_in_wait),
        .i_clr  (w_trip_start),
        .o_wrap (w_sec_wrap)
    );

    tick_prescaler #(.N(WAIT_UNIT_SEC)) u_sec_wunit (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .i_en   (w_sec_wrap),
        .i_clr  (w_trip_start),
        .o_wrap (w_wunit_wrap)
    );

`ifdef TAXI_NIGHT_RATE_EN
    logic r_night;

    // Rate is fixed for the whole trip, whatever night_mode does mid-trip.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)           r_night <= 1'b0;
        else if (w_trip_start) r_night <= bus.night_mode;
    end

    assign w_dist_fare = r_night ? SUM_W'(2 * DIST_FARE) : SUM_W'(DIST_FARE);
    assign w_wait_fare = r_night ? SUM_W'(2 * WAIT_FARE) : SUM_W'(WAIT_FARE);
`else
    assign w_dist_fare = SUM_W'(DIST_FARE);
    assign w_wait_fare = SUM_W'(WAIT_FARE);
`endif

    assign w_dist_inc = sat_inc(r_distance);
    assign w_dist_add = (w_unit_wrap && (w_dist_inc > DIST_W'(BASE_DIST))) ? w_dist_fare : '0;
    assign w_wait_add = w_wunit_wrap ? w_wait_fare : '0;
    // Both charges may land on the same edge; saturate on the combined sum.
    assign w_fare_sum = SUM_W'(r_fare) + w_dist_add + w_wait_add;
    assign w_fare_sat = (w_fare_sum >= SUM_MAX) ? FARE_CAP : w_fare_sum[FARE_W-1:0];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state       <= ST_IDLE;
            r_trip_active <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_trip_active <= (w_state_nxt != ST_IDLE);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_distance <= '0;
            r_wait_sec <= '0;
            r_fare     <= '0;
        end else if (w_trip_start) begin
            r_distance <= '0;
            r_wait_sec <= '0;
            r_fare     <= FARE_BASE;
        end else begin
            if (w_unit_wrap)                 r_distance <= w_dist_inc;
            if (w_sec_wrap)                  r_wait_sec <= sat_inc(r_wait_sec);
            if (w_unit_wrap || w_wunit_wrap) r_fare     <= w_fare_sat;
        end
    end

    assign bus.drive_stat  = r_state;
    assign bus.trip_active = r_trip_active;
    assign bus.distance    = r_distance;
    assign bus.wait_sec    = r_wait_sec;
    assign bus.fare        = r_fare;

endmodule

// File: tb/tb_taxi_fare_ctrl.sv
// Directed bench for taxi_fare_ctrl: a default-cap DUT and a FARE_MAX=135 DUT
// share one stimulus stream.
module tb_taxi_fare_ctrl;

    logic sys_clk;
    logic sys_rst;
    int   checks;
    int   failures;

    taxi_fare_ctrl_if bus_a ();
    taxi_fare_ctrl_if bus_b ();

    assign bus_b.stat_change = bus_a.stat_change;
    assign bus_b.trip_end    = bus_a.trip_end;
    assign bus_b.pulse_tick  = bus_a.pulse_tick;
`ifdef TAXI_NIGHT_RATE_EN
    assign bus_b.night_mode  = bus_a.night_mode;
`endif

    taxi_fare_ctrl #(
        .CLK_TICKS_PER_SEC (10),
        .PULSES_PER_UNIT   (2),
        .BASE_DIST         (3),
        .WAIT_UNIT_SEC     (2)
    ) u_dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus_a)
    );

    taxi_fare_ctrl #(
        .CLK_TICKS_PER_SEC (10),
        .PULSES_PER_UNIT   (2),
        .BASE_DIST         (3),
        .WAIT_UNIT_SEC     (2),
        .FARE_MAX          (135)
    ) u_sat (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus_b)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic strobe_pulse();
        bus_a.pulse_tick = 1'b1;
        step();
        bus_a.pulse_tick = 1'b0;
        step();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        step();
        step();
        checks++; if (bus_a.drive_stat !== 2'b00) begin failures++; $display("FAIL rst_state got=%b exp=00", bus_a.drive_stat); end
        checks++; if (bus_a.trip_active !== 1'b0) begin failures++; $display("FAIL rst_active got=%b exp=0", bus_a.trip_active); end
        checks++; if (bus_a.distance !== 16'd0) begin failures++; $display("FAIL rst_dist got=%0d exp=0", bus_a.distance); end
        checks++; if (bus_a.wait_sec !== 16'd0) begin failures++; $display("FAIL rst_wait got=%0d exp=0", bus_a.wait_sec); end
        checks++; if (bus_a.fare !== 14'd0) begin failures++; $display("FAIL rst_fare got=%0d exp=0", bus_a.fare); end
        sys_rst = 1'b0;
        step();
        bus_a.trip_end = 1'b1;
        step();
        bus_a.trip_end = 1'b0;
        checks++; if (bus_a.drive_stat !== 2'b00) begin failures++; $display("FAIL idle_end_ignored got=%b exp=00", bus_a.drive_stat); end
    endtask

    task automatic test_trip_start();
        bus_a.stat_change = 1'b1;
        step();
        bus_a.stat_change = 1'b0;
        checks++; if (bus_a.drive_stat !== 2'b10) begin failures++; $display("FAIL start_state got=%b exp=10", bus_a.drive_stat); end
        checks++; if (bus_a.trip_active !== 1'b1) begin failures++; $display("FAIL start_active got=%b exp=1", bus_a.trip_active); end
        checks++; if (bus_a.fare !== 14'd130) begin failures++; $display("FAIL start_fare got=%0d exp=130", bus_a.fare); end
        checks++; if (bus_a.distance !== 16'd0) begin failures++; $display("FAIL start_dist got=%0d exp=0", bus_a.distance); end
    endtask

    task automatic test_distance();
        for (int i = 1; i <= 10; i++) begin
            strobe_pulse();
            if (i == 1) begin
                checks++; if (bus_a.distance !== 16'd0) begin failures++; $display("FAIL dist_residue got=%0d exp=0", bus_a.distance); end
            end
            if (i == 6) begin
                checks++; if (bus_a.distance !== 16'd3) begin failures++; $display("FAIL dist_at_base got=%0d exp=3", bus_a.distance); end
                checks++; if (bus_a.fare !== 14'd130) begin failures++; $display("FAIL fare_at_base got=%0d exp=130", bus_a.fare); end
            end
            if (i == 8) begin
                checks++; if (bus_a.fare !== 14'd132) begin failures++; $display("FAIL fare_past_base got=%0d exp=132", bus_a.fare); end
            end
        end
        checks++; if (bus_a.distance !== 16'd5) begin failures++; $display("FAIL dist_10p got=%0d exp=5", bus_a.distance); end
        checks++; if (bus_a.fare !== 14'd134) begin failures++; $display("FAIL fare_10p got=%0d exp=134", bus_a.fare); end
    endtask

    task automatic test_wait();
        // Pulse in the DRIVE->WAIT cycle counts (leaves prescaler residue 1).
        bus_a.stat_change = 1'b1;
        bus_a.pulse_tick  = 1'b1;
        step();
        bus_a.stat_change = 1'b0;
        checks++; if (bus_a.drive_stat !== 2'b01) begin failures++; $display("FAIL wait_state got=%b exp=01", bus_a.drive_stat); end
        for (int i = 0; i < 39; i++) step();
        checks++; if (bus_a.wait_sec !== 16'd3) begin failures++; $display("FAIL wait_39 got=%0d exp=3", bus_a.wait_sec); end
        checks++; if (bus_a.fare !== 14'd139) begin failures++; $display("FAIL fare_wait_39 got=%0d exp=139", bus_a.fare); end
        step();
        bus_a.pulse_tick = 1'b0;
        checks++; if (bus_a.wait_sec !== 16'd4) begin failures++; $display("FAIL wait_40 got=%0d exp=4", bus_a.wait_sec); end
        checks++; if (bus_a.fare !== 14'd144) begin failures++; $display("FAIL fare_wait_40 got=%0d exp=144", bus_a.fare); end
        checks++; if (bus_a.distance !== 16'd5) begin failures++; $display("FAIL dist_in_wait got=%0d exp=5", bus_a.distance); end
        checks++; if (bus_b.fare !== 14'd135) begin failures++; $display("FAIL cap_fare_wait got=%0d exp=135", bus_b.fare); end
        // Pulse in the WAIT->DRIVE cycle is dropped; residue 1 survives the pause.
        bus_a.stat_change = 1'b1;
        bus_a.pulse_tick  = 1'b1;
        step();
        bus_a.stat_change = 1'b0;
        bus_a.pulse_tick  = 1'b0;
        checks++; if (bus_a.drive_stat !== 2'b10) begin failures++; $display("FAIL redrive_state got=%b exp=10", bus_a.drive_stat); end
        checks++; if (bus_a.distance !== 16'd5) begin failures++; $display("FAIL redrive_dist got=%0d exp=5", bus_a.distance); end
        strobe_pulse();
        checks++; if (bus_a.distance !== 16'd6) begin failures++; $display("FAIL resume_dist got=%0d exp=6", bus_a.distance); end
        checks++; if (bus_a.fare !== 14'd146) begin failures++; $display("FAIL resume_fare got=%0d exp=146", bus_a.fare); end
        checks++; if (bus_a.wait_sec !== 16'd4) begin failures++; $display("FAIL resume_wait got=%0d exp=4", bus_a.wait_sec); end
    endtask

    task automatic test_end_priority();
        strobe_pulse();
        bus_a.trip_end    = 1'b1;
        bus_a.stat_change = 1'b1;
        bus_a.pulse_tick  = 1'b1;
        step();
        bus_a.stat_change = 1'b0;
        checks++; if (bus_a.drive_stat !== 2'b00) begin failures++; $display("FAIL end_state got=%b exp=00", bus_a.drive_stat); end
        checks++; if (bus_a.trip_active !== 1'b0) begin failures++; $display("FAIL end_active got=%b exp=0", bus_a.trip_active); end
        checks++; if (bus_a.distance !== 16'd7) begin failures++; $display("FAIL end_dist got=%0d exp=7", bus_a.distance); end
        checks++; if (bus_a.fare !== 14'd148) begin failures++; $display("FAIL end_fare got=%0d exp=148", bus_a.fare); end
        checks++; if (bus_b.fare !== 14'd135) begin failures++; $display("FAIL cap_end_fare got=%0d exp=135", bus_b.fare); end
        for (int i = 0; i < 5; i++) step();
        bus_a.trip_end   = 1'b0;
        bus_a.pulse_tick = 1'b0;
        checks++; if (bus_a.drive_stat !== 2'b00) begin failures++; $display("FAIL frozen_state got=%b exp=00", bus_a.drive_stat); end
        checks++; if (bus_a.distance !== 16'd7) begin failures++; $display("FAIL frozen_dist got=%0d exp=7", bus_a.distance); end
        checks++; if (bus_a.wait_sec !== 16'd4) begin failures++; $display("FAIL frozen_wait got=%0d exp=4", bus_a.wait_sec); end
        checks++; if (bus_a.fare !== 14'd148) begin failures++; $display("FAIL frozen_fare got=%0d exp=148", bus_a.fare); end
        bus_a.stat_change = 1'b1;
        step();
        bus_a.stat_change = 1'b0;
        checks++; if (bus_a.drive_stat !== 2'b10) begin failures++; $display("FAIL new_trip_state got=%b exp=10", bus_a.drive_stat); end
        checks++; if (bus_a.distance !== 16'd0) begin failures++; $display("FAIL new_trip_dist got=%0d exp=0", bus_a.distance); end
        checks++; if (bus_a.wait_sec !== 16'd0) begin failures++; $display("FAIL new_trip_wait got=%0d exp=0", bus_a.wait_sec); end
        checks++; if (bus_a.fare !== 14'd130) begin failures++; $display("FAIL new_trip_fare got=%0d exp=130", bus_a.fare); end
        checks++; if (bus_b.fare !== 14'd130) begin failures++; $display("FAIL cap_new_fare got=%0d exp=130", bus_b.fare); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 40; i++) strobe_pulse();
        checks++; if (bus_a.distance !== 16'd20) begin failures++; $display("FAIL sat_dist got=%0d exp=20", bus_a.distance); end
        checks++; if (bus_a.fare !== 14'd164) begin failures++; $display("FAIL uncapped_fare got=%0d exp=164", bus_a.fare); end
        checks++; if (bus_b.distance !== 16'd20) begin failures++; $display("FAIL cap_dist got=%0d exp=20", bus_b.distance); end
        checks++; if (bus_b.fare !== 14'd135) begin failures++; $display("FAIL cap_fare got=%0d exp=135", bus_b.fare); end
    endtask

    task automatic test_async_reset();
        #2;
        sys_rst = 1'b1;
        #1;
        checks++; if (bus_a.drive_stat !== 2'b00) begin failures++; $display("FAIL arst_state got=%b exp=00", bus_a.drive_stat); end
        checks++; if (bus_a.trip_active !== 1'b0) begin failures++; $display("FAIL arst_active got=%b exp=0", bus_a.trip_active); end
        checks++; if (bus_a.distance !== 16'd0) begin failures++; $display("FAIL arst_dist got=%0d exp=0", bus_a.distance); end
        checks++; if (bus_a.wait_sec !== 16'd0) begin failures++; $display("FAIL arst_wait got=%0d exp=0", bus_a.wait_sec); end
        checks++; if (bus_a.fare !== 14'd0) begin failures++; $display("FAIL arst_fare got=%0d exp=0", bus_a.fare); end
        checks++; if (bus_b.fare !== 14'd0) begin failures++; $display("FAIL arst_cap_fare got=%0d exp=0", bus_b.fare); end
        sys_rst = 1'b0;
        step();
        step();
        checks++; if (bus_a.drive_stat !== 2'b00) begin failures++; $display("FAIL post_rst_state got=%b exp=00", bus_a.drive_stat); end
        // Pulse prescaler must have been cleared by reset: first pulse adds no unit.
        bus_a.stat_change = 1'b1;
        step();
        bus_a.stat_change = 1'b0;
        strobe_pulse();
        checks++; if (bus_a.distance !== 16'd0) begin failures++; $display("FAIL post_rst_dist got=%0d exp=0", bus_a.distance); end
        strobe_pulse();
        checks++; if (bus_a.distance !== 16'd1) begin failures++; $display("FAIL post_rst_unit got=%0d exp=1", bus_a.distance); end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        sys_rst           = 1'b1;
        bus_a.stat_change = 1'b0;
        bus_a.trip_end    = 1'b0;
        bus_a.pulse_tick  = 1'b0;
`ifdef TAXI_NIGHT_RATE_EN
        bus_a.night_mode  = 1'b0;
`endif
        test_reset();
        test_trip_start();
        test_distance();
        test_wait();
        test_end_priority();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
